inst_fetcher: RTL and testbench



---
 rtl/inst_fetcher_pkg.sv | 25 ++
 rtl/inst_queue.sv | 77 +++++++
 rtl/inst_fetcher.sv | 139 +++++++++++++
 tb/tb_inst_fetcher.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetcher_pkg.sv
// Shared widths, opcode constant, FSM encodings and queue entry layout for the instruction fetcher.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package inst_fetcher_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPCODE_JAL = 7'b1101111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pred_pc;
   } fetch_entry_t;

   // Sign-extended J-type immediate; bit 0 is always zero.
   function automatic logic [XLEN-1:0] jal_imm(input logic [XLEN-1:0] d);
      return {{12{d[31]}}, d[19:12], d[20], d[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/inst_queue.sv
// Circular queue of {pc, inst, pred_pc}; head is read combinationally.
// Latency: a push is visible at the head one cycle later.
// Backpressure: none internally; the caller never pushes when full or pops when empty. Flush wins over push/pop.
module inst_queue
   import inst_fetcher_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetch_entry_t             push_dat,
   output fetch_entry_t             head_dat,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            mem_d[tail_q] = push_dat;
            tail_d        = tail_q + PW'(1);
         end
         if (pop) begin
            head_d = head_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: entries are only read while count is non-zero.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head_dat = mem_q[head_q];
   assign count    = count_q;
   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);

endmodule

// File: rtl/inst_fetcher.sv
// Fetches one instruction word at a time and queues {pc, inst, pred_pc} for decode; JAL_PREDICT_EN adds JAL target prediction.
// Latency: push one cycle after mem_done; one instruction per (memory latency + 2) cycles.
// Backpressure: no request while the queue is full; rdy low freezes everything; redirect flushes and drops any in-flight word.
module inst_fetcher
   import inst_fetcher_pkg::*;
#(
   parameter int          QUEUE_DEPTH = 8,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   output logic        mem_req_valid,
   output logic [31:0] mem_req_addr,
   input  logic        mem_done,
   input  logic [31:0] mem_data,
   output logic        out_valid,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic [31:0] out_pred_pc,
   input  logic        out_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam int CW = $clog2(QUEUE_DEPTH) + 1;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            req_vld_q, req_vld_d;
   logic [XLEN-1:0] req_addr_q, req_addr_d;
   logic [XLEN-1:0] next_pc;
   logic            push_req;

   logic            q_push, q_pop, q_flush;
   logic            q_full, q_empty;
   logic [CW-1:0]   q_count;
   fetch_entry_t    q_push_dat, q_head;

   always_comb begin
      next_pc = pc_q + 32'd4;
`ifdef JAL_PREDICT_EN
      if (mem_data[6:0] == OPCODE_JAL) begin
         next_pc = pc_q + jal_imm(mem_data);
      end
`endif
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_vld_d  = req_vld_q;
      req_addr_d = req_addr_q;
      push_req   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (redirect_valid) begin
               pc_d = redirect_pc;
            end else if (!q_full) begin
               req_vld_d  = 1'b1;
               req_addr_d = pc_q;
               state_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // A response landing together with a redirect belongs to the old path.
            if (redirect_valid) begin
               pc_d = redirect_pc;
               if (mem_done) begin
                  req_vld_d = 1'b0;
                  state_d   = ST_IDLE;
               end else begin
                  state_d = ST_DROP;
               end
            end else if (mem_done) begin
               push_req  = 1'b1;
               pc_d      = next_pc;
               req_vld_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         ST_DROP: begin
            if (redirect_valid) begin
               pc_d = redirect_pc;
            end
            if (mem_done) begin
               req_vld_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            req_vld_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         req_vld_q  <= 1'b0;
         req_addr_q <= '0;
      end else if (rdy) begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_vld_q  <= req_vld_d;
         req_addr_q <= req_addr_d;
      end
   end

   assign q_push_dat = '{pc: pc_q, inst: mem_data, pred_pc: next_pc};
   assign q_flush    = rdy & redirect_valid;
   assign q_push     = rdy & push_req;
   assign q_pop      = rdy & out_ready & ~q_empty & ~redirect_valid;

   inst_queue #(
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk      (clk),
      .rst      (rst),
      .push     (q_push),
      .pop      (q_pop),
      .flush    (q_flush),
      .push_dat (q_push_dat),
      .head_dat (q_head),
      .count    (q_count),
      .full     (q_full),
      .empty    (q_empty)
   );

   assign mem_req_valid = req_vld_q;
   assign mem_req_addr  = req_addr_q;
   assign out_valid     = (q_count != '0);
   assign out_inst      = q_head.inst;
   assign out_pc        = q_head.pc;
   assign out_pred_pc   = q_head.pred_pc;

endmodule

// File: tb/tb_inst_fetcher.sv
// Testbench for inst_fetcher: memory responder plus reference fetch model feeding a scoreboard; a monitor checks every pop.
// Directed scenarios first, then randomized redirects, backpressure and rdy stalls.
module tb_inst_fetcher;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] pred;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, rdy;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_done;
   logic [31:0] mem_data;
   logic        out_valid;
   logic [31:0] out_inst, out_pc, out_pred_pc;
   logic        out_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   always #5 clk = ~clk;

   inst_fetcher #(
      .QUEUE_DEPTH (8),
      .RESET_PC    (32'h0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_done       (mem_done),
      .mem_data       (mem_data),
      .out_valid      (out_valid),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .out_pred_pc    (out_pred_pc),
      .out_ready      (out_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   // Scoreboard and reference model state
   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] model_pc = 32'h0;
   bit          outstanding = 0;
   bit          discard = 0;
   int          lat = 0;
   logic [31:0] req_pc_m = 32'h0;
   logic [31:0] img [logic [31:0]];
   int          req_cnt = 0;
   int          done_cnt = 0;

   // Stimulus controls
   bit          drv_en = 0;
   int          cfg_lat = -1;
   int          cfg_ready_mode = 0;
   bit          cfg_pop_once = 0;
   bit          cfg_nop = 1;
   bit          cfg_rand_redir = 0;
   bit          cfg_rand_rdy = 0;
   bit          cfg_hold = 0;
   bit          force_redir = 0;
   logic [31:0] force_rpc = 32'h0;
   bit          redir_on_done = 0;
   logic [31:0] rod_pc = 32'h0;
   bit          chk_flush = 0;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // Next-PC rule: pc+4 with 32-bit wrap, or the JAL target when prediction is built in.
   function automatic logic [31:0] ref_pred(input logic [31:0] pc, input logic [31:0] w);
      logic signed [20:0] off;
`ifdef JAL_PREDICT_EN
      if (w[6:0] == 7'b1101111) begin
         off = {w[31], w[19:12], w[20], w[30:21], 1'b0};
         return pc + 32'(off);
      end
`endif
      off = 21'sd4;
      return pc + 32'(off);
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] r;
      r = $urandom();
      if ($urandom_range(0, 3) == 0) r[6:0] = 7'b1101111;
      return r;
   endfunction

   task automatic drive_cycle();
      bit          do_redir, do_done;
      logic [31:0] rpc, w;
      exp_t        e;
      do_redir = 0;
      do_done  = 0;
      rpc      = 32'h0;
      w        = 32'h0;
      if (mem_req_valid && !outstanding) begin
         check("req_addr", mem_req_addr, model_pc);
         req_cnt++;
         outstanding = 1;
         discard     = 0;
         req_pc_m    = model_pc;
         lat         = (cfg_lat >= 0) ? cfg_lat : int'($urandom_range(0, 3));
      end
      if (outstanding && !cfg_hold) begin
         if (lat == 0) begin
            do_done = 1;
            if (img.exists(req_pc_m)) w = img[req_pc_m];
            else if (cfg_nop)         w = 32'h00000013;
            else                      w = rand_word();
         end else begin
            lat--;
         end
      end
      if (force_redir) begin
         do_redir    = 1;
         rpc         = force_rpc;
         force_redir = 0;
      end else if (do_done && redir_on_done) begin
         do_redir      = 1;
         rpc           = rod_pc;
         redir_on_done = 0;
      end else if (cfg_rand_redir && $urandom_range(0, 19) == 0) begin
         do_redir = 1;
         rpc      = $urandom() & 32'hFFFF_FFFC;
      end
      rdy = 1'b1;
      if (cfg_rand_rdy && !do_done && !do_redir && $urandom_range(0, 7) == 0) rdy = 1'b0;
      mem_done       = do_done;
      mem_data       = do_done ? w : $urandom();
      redirect_valid = do_redir;
      redirect_pc    = do_redir ? rpc : $urandom();
      case (cfg_ready_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
      if (cfg_pop_once) begin
         out_ready    = 1'b1;
         cfg_pop_once = 0;
      end
      if (do_done) begin
         outstanding = 0;
         done_cnt++;
      end
      if (do_redir) begin
         exp_q.delete();
         model_pc = rpc;
         if (outstanding) discard = 1;
      end else if (do_done && !discard) begin
         e = {req_pc_m, w, ref_pred(req_pc_m, w)};
         exp_q.push_back(e);
         model_pc = e.pred;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (drv_en) drive_cycle();
      end
   end

   // Monitor: every accepted head is compared with the oldest expected entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (chk_flush) check("flush_out_valid", {95'h0, out_valid}, 96'h0);
         chk_flush = drv_en && !rst && rdy && redirect_valid;
         if (!rst && rdy && out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL pop_unexpected: got pc %h inst %h, required no entry", out_pc, out_inst);
            end else begin
               e = exp_q.pop_front();
               check("pop_entry", {out_pc, out_inst, out_pred_pc}, e);
            end
         end
      end
   end

   task automatic wait_out_valid(input string name);
      for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
      if (!out_valid) timeout_fail(name);
   endtask

   task automatic wait_reqs(input int n, input string name);
      for (int i = 0; i < 60 && req_cnt < n; i++) @(negedge clk);
      if (req_cnt < n) timeout_fail(name);
   endtask

   task automatic wait_done(input int dc, input string name);
      for (int i = 0; i < 40 && done_cnt <= dc; i++) @(negedge clk);
      if (done_cnt <= dc) timeout_fail(name);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          r0, rq, dc;
      bit          found;
      logic [31:0] exp_jal;
`ifdef JAL_PREDICT_EN
      exp_jal = 32'h30;
`else
      exp_jal = 32'h24;
`endif
      rst = 1'b1; rdy = 1'b1; mem_done = 1'b0; mem_data = 32'h0;
      out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", {95'h0, out_valid}, 96'h0);
      check("rst_req_valid", {95'h0, mem_req_valid}, 96'h0);
      check("rst_req_addr", {64'h0, mem_req_addr}, 96'h0);

      // First fetch from reset, response after 3 cycles
      img[32'h0] = 32'h00500093;
      cfg_lat = 3; cfg_ready_mode = 0; cfg_nop = 1;
      model_pc = 32'h0;
      rst = 1'b0; drv_en = 1;
      wait_reqs(1, "t1_first_req");
      check("t1_first_addr", {64'h0, mem_req_addr}, 96'h0);
      wait_out_valid("t1_out_valid");
      check("t1_head", {out_pc, out_inst, out_pred_pc}, {32'h0, 32'h00500093, 32'h4});
      rq = req_cnt;
      wait_reqs(rq + 1, "t1_next_req");
      check("t1_next_addr", {64'h0, mem_req_addr}, {64'h0, 32'h4});
      img.delete();

      // Fill the queue with the consumer stalled, then free one slot
      cfg_lat = 0; force_rpc = 32'h0; force_redir = 1;
      @(negedge clk);
      r0 = req_cnt;
      repeat (40) @(negedge clk);
      check("t2_fetch_count", 96'(req_cnt - r0), 96'd8);
      check("t2_req_valid_full", {95'h0, mem_req_valid}, 96'h0);
      check("t2_out_valid_full", {95'h0, out_valid}, 96'h1);
      cfg_pop_once = 1;
      wait_reqs(r0 + 9, "t2_req_after_pop");
      check("t2_addr_after_pop", {64'h0, mem_req_addr}, {64'h0, 32'd32});

      // Redirect while the request to 8 is in flight; its response is dropped
      cfg_lat = 4; force_rpc = 32'h0; force_redir = 1;
      found = 0;
      for (int i = 0; i < 80 && !found; i++) begin
         @(negedge clk);
         found = mem_req_valid && mem_req_addr == 32'h8;
      end
      if (!found) timeout_fail("t3_req_8");
      img[32'h8] = 32'hDEADBEEF;
      force_rpc = 32'h100; force_redir = 1;
      dc = done_cnt;
      wait_done(dc, "t3_drop_done");
      @(negedge clk);
      check("t3_out_valid_after_drop", {95'h0, out_valid}, 96'h0);
      check("t3_req_valid_after_drop", {95'h0, mem_req_valid}, 96'h0);
      rq = req_cnt;
      wait_reqs(rq + 1, "t3_next_req");
      check("t3_next_addr", {64'h0, mem_req_addr}, {64'h0, 32'h100});
      img.delete();

      // Redirect coinciding with mem_done while BUSY
      cfg_lat = 2; rod_pc = 32'h200; redir_on_done = 1;
      dc = done_cnt;
      wait_done(dc, "t4_done");
      @(negedge clk);
      check("t4_req_valid_idle", {95'h0, mem_req_valid}, 96'h0);
      check("t4_out_valid", {95'h0, out_valid}, 96'h0);
      rq = req_cnt;
      wait_reqs(rq + 1, "t4_next_req");
      check("t4_next_addr", {64'h0, mem_req_addr}, {64'h0, 32'h200});

      // JAL word at 0x20
      img[32'h20] = 32'h0100006F;
      force_rpc = 32'h20; force_redir = 1;
      repeat (2) @(negedge clk);
      wait_out_valid("t5_out_valid");
      check("t5_head", {out_pc, out_inst, out_pred_pc}, {32'h20, 32'h0100006F, exp_jal});
      rq = req_cnt;
      wait_reqs(rq + 1, "t5_next_req");
      check("t5_next_addr", {64'h0, mem_req_addr}, {64'h0, exp_jal});

      // PC wrap-around at the top of the address space
      force_rpc = 32'hFFFF_FFFC; force_redir = 1;
      repeat (2) @(negedge clk);
      wait_out_valid("t6_out_valid");
      check("t6_head", {out_pc, out_inst, out_pred_pc}, {32'hFFFF_FFFC, 32'h00000013, 32'h0});
      rq = req_cnt;
      wait_reqs(rq + 1, "t6_next_req");
      check("t6_next_addr", {64'h0, mem_req_addr}, 96'h0);
      img.delete();

      // Randomized traffic
      cfg_nop = 0; cfg_lat = -1; cfg_ready_mode = 2;
      cfg_rand_redir = 1; cfg_rand_rdy = 1;
      repeat (1500) @(negedge clk);

      // Stop memory responses and drain the queue
      cfg_rand_redir = 0; cfg_rand_rdy = 0; cfg_hold = 1; cfg_ready_mode = 1;
      repeat (30) @(negedge clk);
      check("drain_out_valid", {95'h0, out_valid}, 96'h0);
      check("drain_leftover", 96'(exp_q.size()), 96'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
